// File: rtl/lcd_pkg.sv
// Shared types and helpers for the HD44780 responder: FSM states, instruction
// classes, DDRAM geometry and address-counter conversion.
package lcd_pkg;

    localparam int         DDRAM_DEPTH = 32;
    localparam logic [6:0] LINE2_BASE  = 7'h40;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_CLEAR  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE    = 4'd0,
        OP_CLEAR   = 4'd1,
        OP_HOME    = 4'd2,
        OP_ENTRY   = 4'd3,
        OP_DISPLAY = 4'd4,
        OP_SHIFT   = 4'd5,
        OP_FUNC    = 4'd6,
        OP_CGRAM   = 4'd7,
        OP_DDRAM   = 4'd8
    } op_t;

    // Instruction class is chosen by the highest set bit of the command byte.
    function automatic op_t decode_instr(input logic [7:0] c);
        op_t op;
        op = OP_NONE;
        casez (c)
            8'b1???????: op = OP_DDRAM;
            8'b01??????: op = OP_CGRAM;
            8'b001?????: op = OP_FUNC;
            8'b0001????: op = OP_SHIFT;
            8'b00001???: op = OP_DISPLAY;
            8'b000001??: op = OP_ENTRY;
            8'b0000001?: op = OP_HOME;
            8'b00000001: op = OP_CLEAR;
            default:     op = OP_NONE;
        endcase
        return op;
    endfunction

    // Linear index 0..31 to the HD44780 address counter (line 2 starts at 0x40).
    function automatic logic [6:0] idx_to_ac(input logic [4:0] idx);
        return idx[4] ? (LINE2_BASE | {3'b000, idx[3:0]}) : {3'b000, idx[3:0]};
    endfunction

endpackage

// File: rtl/lcd_bus_sampler.sv
// Brings the asynchronous LCD bus into the clk domain and detects the edges of
// the enable strobe; rs/rw/data are reported from the same stage as e.
module lcd_bus_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] data,
    output logic       e_sync,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       rs_sync,
    output logic       rw_sync,
    output logic [7:0] data_sync
);

    logic [10:0] sync_q [SYNC_STAGES];
    logic        e_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            e_prev <= 1'b0;
        end else begin
            sync_q[0] <= {e, rs, rw, data};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            e_prev <= sync_q[SYNC_STAGES-1][10];
        end
    end

    assign e_sync     = sync_q[SYNC_STAGES-1][10];
    assign rs_sync    = sync_q[SYNC_STAGES-1][9];
    assign rw_sync    = sync_q[SYNC_STAGES-1][8];
    assign data_sync  = sync_q[SYNC_STAGES-1][7:0];
    assign rise_pulse = e_sync & ~e_prev;
    assign fall_pulse = ~e_sync & e_prev;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Device end of an HD44780 16x2 parallel bus: decodes instructions and data
// writes into a 32-char DDRAM image, answers busy-flag/data reads, flags misuse.
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CMD_CYCLES = 80000,
    parameter int BUSY_OP_CYCLES  = 2500,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic [4:0] ddram_addr,
    output logic       display_on,
    output logic       frame_done,
    output logic       err_busy_wr,
    output logic       err_bad_addr
);

    localparam int BUSY_MAX = (BUSY_CMD_CYCLES > BUSY_OP_CYCLES) ? BUSY_CMD_CYCLES : BUSY_OP_CYCLES;
    localparam int CNT_W    = $clog2(BUSY_MAX + 1);
    localparam logic [CNT_W-1:0] LOAD_CMD = CNT_W'(BUSY_CMD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_OP  = CNT_W'(BUSY_OP_CYCLES - 1);

    logic       e_s, rise, fall, s_rs, s_rw;
    logic [7:0] s_data;

    lcd_bus_sampler #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .e         (lcd_e),
        .rs        (lcd_rs),
        .rw        (lcd_rw),
        .data      (lcd_data_in),
        .e_sync    (e_s),
        .rise_pulse(rise),
        .fall_pulse(fall),
        .rs_sync   (s_rs),
        .rw_sync   (s_rw),
        .data_sync (s_data)
    );

    logic [7:0]       ddram [DDRAM_DEPTH];
    state_t           state;
    logic [4:0]       clr_idx;
    logic             cmd_rs;
    logic [7:0]       cmd_data;
    logic             incr;
    logic [CNT_W-1:0] busy_cnt;

    op_t        op;
    logic       accept, start_busy, long_busy;
    logic       set_valid;
    logic [4:0] set_idx;

    function automatic logic [4:0] step_addr(input logic [4:0] a, input logic up);
        return up ? a + 5'd1 : a - 5'd1;
    endfunction

    // Function set bypasses the busy check so the init sequence can run
    // back-to-back, and it never restarts the busy window.
    always_comb begin
        op         = decode_instr(cmd_data);
        accept     = 1'b0;
        start_busy = 1'b0;
        long_busy  = 1'b0;
        if (state == S_DECODE) begin
            accept     = !busy || (!cmd_rs && op == OP_FUNC);
            start_busy = accept && (cmd_rs || op != OP_FUNC);
            long_busy  = !cmd_rs && (op == OP_CLEAR || op == OP_HOME);
        end
        set_valid = (cmd_data[6:4] == 3'b000) || (cmd_data[6:4] == 3'b100);
        set_idx   = {cmd_data[6], cmd_data[3:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            busy_cnt <= '0;
        end else if (start_busy) begin
            busy     <= 1'b1;
            busy_cnt <= long_busy ? LOAD_CMD : LOAD_OP;
        end else if (busy) begin
            if (busy_cnt == '0) begin
                busy <= 1'b0;
            end else begin
                busy_cnt <= busy_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            for (int i = 0; i < DDRAM_DEPTH; i++) begin
                ddram[i] <= CHAR_SPACE;
            end
            clr_idx      <= '0;
            cmd_rs       <= 1'b0;
            cmd_data     <= '0;
            incr         <= 1'b1;
            ddram_addr   <= '0;
            display_on   <= 1'b0;
            frame_done   <= 1'b0;
            err_busy_wr  <= 1'b0;
            err_bad_addr <= 1'b0;
            lcd_data_out <= '0;
            lcd_data_oe  <= 1'b0;
            rd_char      <= '0;
        end else begin
            frame_done  <= 1'b0;
            rd_char     <= ddram[rd_addr];
            lcd_data_oe <= e_s & s_rw;
            // Read data is frozen at the rising edge of e so it stays stable while e is high.
            if (rise) begin
                lcd_data_out <= s_rs ? ddram[ddram_addr] : {busy, idx_to_ac(ddram_addr)};
            end
            if (fall && !s_rw && state != S_IDLE) begin
                err_busy_wr <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        if (s_rw) begin
                            if (s_rs) begin
                                ddram_addr <= step_addr(ddram_addr, incr);
                            end
                        end else begin
                            cmd_rs   <= s_rs;
                            cmd_data <= s_data;
                            state    <= S_DECODE;
                        end
                    end
                end

                S_DECODE: begin
                    state <= S_IDLE;
                    if (!accept) begin
                        err_busy_wr <= 1'b1;
                    end else if (cmd_rs) begin
                        ddram[ddram_addr] <= cmd_data;
                        ddram_addr        <= step_addr(ddram_addr, incr);
                        if (ddram_addr == 5'd31) begin
                            frame_done <= 1'b1;
                        end
                    end else begin
                        case (op)
                            OP_DDRAM: begin
                                if (set_valid) begin
                                    ddram_addr <= set_idx;
                                end else begin
                                    err_bad_addr <= 1'b1;
                                end
                            end
                            OP_SHIFT: begin
                                if (!cmd_data[3]) begin
                                    ddram_addr <= step_addr(ddram_addr, cmd_data[2]);
                                end
                            end
                            OP_DISPLAY: display_on <= cmd_data[2];
                            OP_ENTRY:   incr       <= cmd_data[1];
                            OP_HOME:    ddram_addr <= '0;
                            OP_CLEAR: begin
                                clr_idx <= '0;
                                state   <= S_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end

                S_CLEAR: begin
                    ddram[clr_idx] <= CHAR_SPACE;
                    clr_idx        <= clr_idx + 5'd1;
                    if (clr_idx == 5'd31) begin
                        ddram_addr <= '0;
                        incr       <= 1'b1;
                        state      <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
